// File: rtl/operand_mux_pkg.sv
// Shared types for the operand select pipeline.
// Occupancy encoding of the output register pair and source channel ids.
package operand_mux_pkg;

  localparam int OP_SRC_IMEM = 0;
  localparam int OP_SRC_REGB = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_FULL,
    OCC_SKID
  } occ_e;

endpackage

// File: rtl/operand_mux_sel.sv
// Combinational N-to-1 operand select.
// Selects outside the channel range yield zero and raise illegal.
module operand_mux_sel
  import operand_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] srcs,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    illegal
);

  always_comb begin
    data    = '0;
    illegal = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data    = srcs[k*WIDTH +: WIDTH];
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_mux_pipe.sv
// Registered operand selector with valid/ready and a 2-entry skid buffer.
// Optional output transfer counter: define OPERAND_MUX_XFER_CNT_EN.
module operand_mux_pipe
  import operand_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        in_sel_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_sel_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    sel_err_o,
`ifdef OPERAND_MUX_XFER_CNT_EN
  output logic [15:0]             xfer_cnt_o,
`endif
  input  logic                    err_clr_i
);

  occ_e             state_q, state_d;
  logic             ready_q;
  logic [WIDTH-1:0] main_data_q, skid_data_q;
  logic [SEL_W-1:0] main_sel_q, skid_sel_q;
  logic             err_q;
  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             in_xfer, out_xfer;
  logic             ld_in, ld_skid, ld_pop;

  operand_mux_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .srcs    (in_data_i),
    .sel     (in_sel_i),
    .data    (sel_data),
    .illegal (sel_bad)
  );

  assign out_valid_o = (state_q != OCC_EMPTY);
  assign in_ready_o  = ready_q;
  assign out_data_o  = main_data_q;
  assign out_sel_o   = main_sel_q;
  assign sel_err_o   = err_q;
  assign in_xfer     = in_valid_i & ready_q;
  assign out_xfer    = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    ld_pop  = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (in_xfer) begin
          state_d = OCC_FULL;
          ld_in   = 1'b1;
        end
      end
      OCC_FULL: begin
        if (in_xfer && out_xfer) begin
          ld_in = 1'b1;
        end else if (out_xfer) begin
          state_d = OCC_EMPTY;
        end else if (in_xfer) begin
          state_d = OCC_SKID;
          ld_skid = 1'b1;
        end
      end
      OCC_SKID: begin
        if (out_xfer) begin
          state_d = OCC_FULL;
          ld_pop  = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // ready is registered from the next state so no comb path reaches it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OCC_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != OCC_SKID);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      if (ld_in) begin
        main_data_q <= sel_data;
        main_sel_q  <= in_sel_i;
      end else if (ld_pop) begin
        main_data_q <= skid_data_q;
        main_sel_q  <= skid_sel_q;
      end
      if (ld_skid) begin
        skid_data_q <= sel_data;
        skid_sel_q  <= in_sel_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (in_xfer && sel_bad) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

`ifdef OPERAND_MUX_XFER_CNT_EN
  logic [15:0] cnt_q;

  assign xfer_cnt_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (err_clr_i) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`endif

endmodule
